// File: rtl/memwb_stage.sv
// Memory-response / writeback stage: aligns load data, selects the writeback value and registers the regfile write.
// Optional MEMWB_MISALIGN_TRAP_EN flags misaligned LH/LHU/LW and suppresses their register write.
module memwb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] inst_i,
    input  logic [XLEN-1:0] r0data_i,
    input  logic [XLEN-1:0] r1data_i,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] datamemrdata_i,
    output logic            valid_ro,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_ro,
    output logic [XLEN-1:0] inst_ro,
    output logic            regwrite_ro,
    output logic [4:0]      regaddr_ro,
    output logic [XLEN-1:0] regdata_ro,
    output logic            misalign_ro
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    logic            cke;
    logic            first_q;
    logic            hold_valid;
    logic [XLEN-1:0] hold_data;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rd;
    logic            is_load;
    logic            wb_op;
    logic [1:0]      addr_lo;
    logic [XLEN-1:0] mem_word;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] load_data;
    logic            misalign_d;
    logic            regwrite_d;
    logic [XLEN-1:0] wb_data;
    logic            unused_bits;

    assign cke     = ~valid_ro | ready_i;
    assign ready_o = cke;

    assign opcode  = inst_i[6:0];
    assign funct3  = inst_i[14:12];
    assign rd      = inst_i[11:7];
    assign is_load = (opcode == OPC_LOAD);
    assign addr_lo = r0data_i[1:0] + inst_i[21:20];

    assign unused_bits = ^{r1data_i, r0data_i[XLEN-1:2]};

    // The memory word is only valid in the first cycle a load is presented; later stall cycles use the held copy.
    assign mem_word = hold_valid ? hold_data : datamemrdata_i;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (addr_lo)
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            2'd3:    byte_sel = mem_word[31:24];
            default: byte_sel = mem_word[7:0];
        endcase
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        case (funct3)
            3'b000:  load_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            3'b001:  load_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            3'b010:  load_data = mem_word;
            3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_sel};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, half_sel};
            default: load_data = '1;
        endcase
    end

    always_comb begin
        case (opcode)
            OPC_LOAD, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: wb_op = 1'b1;
            default: wb_op = 1'b0;
        endcase
    end

`ifdef MEMWB_MISALIGN_TRAP_EN
    always_comb begin
        misalign_d = 1'b0;
        if (is_load) begin
            case (funct3)
                3'b001, 3'b101: misalign_d = addr_lo[0];
                3'b010:         misalign_d = (addr_lo != 2'd0);
                default:        misalign_d = 1'b0;
            endcase
        end
    end
`else
    assign misalign_d = 1'b0;
`endif

    assign regwrite_d = valid_i & wb_op & (rd != 5'd0) & ~misalign_d;
    assign wb_data    = regwrite_d ? (is_load ? load_data : result_i) : '0;

    // first_q drops only while a valid input sits stalled, so a load arriving behind a stalled bubble still counts as new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            first_q    <= 1'b1;
            hold_valid <= 1'b0;
            hold_data  <= '0;
        end else begin
            first_q <= cke | ~valid_i;
            if (cke & valid_i) begin
                hold_valid <= 1'b0;
            end else if (valid_i & is_load & first_q & ~cke & ~hold_valid) begin
                hold_valid <= 1'b1;
                hold_data  <= datamemrdata_i;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_ro    <= 1'b0;
            pc_ro       <= '0;
            inst_ro     <= '0;
            regwrite_ro <= 1'b0;
            regaddr_ro  <= '0;
            regdata_ro  <= '0;
        end else if (cke) begin
            valid_ro    <= valid_i;
            pc_ro       <= pc_i;
            inst_ro     <= inst_i;
            regwrite_ro <= regwrite_d;
            regaddr_ro  <= rd;
            regdata_ro  <= wb_data;
        end
    end

`ifdef MEMWB_MISALIGN_TRAP_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            misalign_ro <= 1'b0;
        end else if (cke) begin
            misalign_ro <= valid_i & misalign_d;
        end
    end
`else
    assign misalign_ro = 1'b0;
`endif

endmodule
